// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional feature macro used by the arbiter: DMEM_ARB_LOCK_EN (adds per-master lock inputs).
// req_t is sized by REQ_ADDR_W/REQ_DATA_W. These match the arbiter's default ADDR_W/DATA_W,
// so change them together with those parameters.
package dmem_arb_pkg;

    localparam int MAX_BURST_DEF = 8;
    localparam int REQ_ADDR_W    = 16;
    localparam int REQ_DATA_W    = 16;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_P    = 2'd1,
        OWN_D    = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_arbiter_burst_cnt.sv
// Saturating burst-length counter for the data-memory arbiter.
// clr has priority over load1, and load1 has priority over inc.
// The count holds once it reaches MAX_BURST.
module arb_burst_cnt
    import dmem_arb_pkg::*;
#(
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load1,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    // run length of the current owner: restart at 1 on handover, count up to the cap, clear when idle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CNT_W'(1);
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the processor data port (P) and a loader/DMA master (D).
// It grants at most one access per cycle and keeps ownership with the last owner (parking).
// The burst cap hands the port over once the owner has had MAX_BURST grants in a row
// while the other master waits. Read data comes back one cycle after the grant.
// Optional macro DMEM_ARB_LOCK_EN adds p_lock/d_lock. While its lock and request are both
// high, the owner is not pre-empted by the burst cap.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = REQ_ADDR_W,
    parameter int DATA_W     = REQ_DATA_W,
    parameter int DMEM_DEPTH = 12,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                  p_lock,
    input  logic                  d_lock,
`endif
    input  logic                  p_req,
    input  logic                  p_we,
    input  logic [ADDR_W-1:0]     p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    output logic                  p_gnt,
    output logic                  p_rvalid,
    output logic [DATA_W-1:0]     p_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_we,
    output logic [DMEM_DEPTH-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e              state_q;
    arb_state_e              state_d;
    logic [CNT_W-1:0]        cnt;
    logic                    cnt_sat;
    logic                    cnt_load1;
    logic                    cnt_inc;
    logic                    cnt_clr;
    logic                    p_cap;
    logic                    d_cap;
    logic                    any_gnt;
    req_t                    sel;
    logic                    sel_hit;
    logic [DMEM_DEPTH-1:0]   addr_hold_q;
    logic [DATA_W-1:0]       wdata_hold_q;
    logic                    p_vld_p1;
    logic                    d_vld_p1;
    logic                    hit_p1;

    arb_burst_cnt #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (cnt)
    );

    assign cnt_sat = (cnt == CNT_W'(MAX_BURST));

    // The cap only forces a handover when the owner is not inside a locked sequence.
`ifdef DMEM_ARB_LOCK_EN
    assign p_cap = cnt_sat && !p_lock;
    assign d_cap = cnt_sat && !d_lock;
`else
    assign p_cap = cnt_sat;
    assign d_cap = cnt_sat;
`endif

    // grant decision, next owner and burst-counter control
    always_comb begin
        p_gnt     = 1'b0;
        d_gnt     = 1'b0;
        state_d   = OWN_IDLE;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            OWN_P: begin
                if (p_req && !(d_req && p_cap)) p_gnt = 1'b1;
                else if (d_req)                 d_gnt = 1'b1;
            end
            OWN_D: begin
                if (d_req && !(p_req && d_cap)) d_gnt = 1'b1;
                else if (p_req)                 p_gnt = 1'b1;
            end
            default: begin
                if (p_req)      p_gnt = 1'b1;
                else if (d_req) d_gnt = 1'b1;
            end
        endcase
        if (p_gnt) begin
            state_d   = OWN_P;
            cnt_inc   = (state_q == OWN_P);
            cnt_load1 = (state_q != OWN_P);
        end else if (d_gnt) begin
            state_d   = OWN_D;
            cnt_inc   = (state_q == OWN_D);
            cnt_load1 = (state_q != OWN_D);
        end else begin
            cnt_clr   = 1'b1;
        end
    end

    // ownership register: remembers the last granted master
    always_ff @(posedge clk) begin
        if (rst) state_q <= OWN_IDLE;
        else     state_q <= state_d;
    end

    // route the granted master's request onto the memory side
    always_comb begin
        sel = '0;
        if (d_gnt) begin
            sel.we    = d_we;
            sel.addr  = REQ_ADDR_W'(d_addr);
            sel.wdata = REQ_DATA_W'(d_wdata);
        end else begin
            sel.we    = p_we;
            sel.addr  = REQ_ADDR_W'(p_addr);
            sel.wdata = REQ_DATA_W'(p_wdata);
        end
    end

    assign any_gnt = p_gnt || d_gnt;
    assign sel_hit = ((sel.addr >> DMEM_DEPTH) == '0);
    assign m_we    = any_gnt && sel.we && sel_hit && !rst;
    assign m_addr  = any_gnt ? sel.addr[DMEM_DEPTH-1:0] : addr_hold_q;
    assign m_wdata = any_gnt ? DATA_W'(sel.wdata) : wdata_hold_q;

    // keep the last driven address/data so the memory bus stays quiet between grants
    always_ff @(posedge clk) begin
        if (any_gnt) begin
            addr_hold_q  <= sel.addr[DMEM_DEPTH-1:0];
            wdata_hold_q <= DATA_W'(sel.wdata);
        end
    end

    // ---- p1: read return, one cycle after the grant ----
    // note which master took a read and whether it hit the memory
    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld_p1 <= 1'b0;
            d_vld_p1 <= 1'b0;
            hit_p1   <= 1'b0;
        end else begin
            p_vld_p1 <= p_gnt && !p_we;
            d_vld_p1 <= d_gnt && !d_we;
            hit_p1   <= sel_hit;
        end
    end

    assign p_rvalid = p_vld_p1;
    assign d_rvalid = d_vld_p1;
    assign p_rdata  = (p_vld_p1 && hit_p1) ? m_rdata : '0;
    assign d_rdata  = (d_vld_p1 && hit_p1) ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a scoreboard.
// The block under DMEM_ARB_LOCK_EN exercises the lock inputs when that macro is defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int DMEM_DEPTH = 12;
    localparam int MAX_BURST  = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  p_req = 1'b0, p_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0]     p_addr = '0, d_addr = '0;
    logic [DATA_W-1:0]     p_wdata = '0, d_wdata = '0;
    logic                  p_gnt, p_rvalid, d_gnt, d_rvalid, m_we;
    logic [DATA_W-1:0]     p_rdata, d_rdata, m_wdata;
    logic [DMEM_DEPTH-1:0] m_addr;
    logic [DATA_W-1:0]     m_rdata = '0;
    logic                  p_lock = 1'b0, d_lock = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMEM_DEPTH(DMEM_DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef DMEM_ARB_LOCK_EN
        .p_lock(p_lock), .d_lock(d_lock),
`endif
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // synchronous single-port memory: read data one cycle after the address
    logic [DATA_W-1:0] mem [0:(1<<DMEM_DEPTH)-1] = '{default: '0};
    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    // reference model state
    int                checks = 0;
    int                errors = 0;
    int                own = 0;      // 0 nobody, 1 P, 2 D
    int                run = 0;      // consecutive grants to the current owner
    logic [DATA_W-1:0] ref_mem [0:(1<<DMEM_DEPTH)-1] = '{default: '0};
    logic [DATA_W-1:0] p_exp[$];
    logic [DATA_W-1:0] d_exp[$];
    int                hist[$];
    logic [DMEM_DEPTH-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_wdata = '0;
    bit                last_v = 1'b0;
    bit                mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // who should be granted now, from the arbitration rules
    function automatic int model_gnt();
        bit want[3];
        bit lk[3];
        int other;
        want[0] = 1'b0; want[1] = p_req; want[2] = d_req;
        lk[0] = 1'b0; lk[1] = 1'b0; lk[2] = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lk[1] = p_lock; lk[2] = d_lock;
`endif
        if (own == 0) return p_req ? 1 : (d_req ? 2 : 0);
        other = 3 - own;
        if (want[own] && !(want[other] && run >= MAX_BURST && !lk[own])) return own;
        if (want[other]) return other;
        return 0;
    endfunction

    // one clock: inputs already applied at the falling edge
    task automatic step();
        int g;
        logic we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        bit hit;
        #1;
        g = model_gnt();
        check("p_gnt", 32'(p_gnt), 32'(g == 1));
        check("d_gnt", 32'(d_gnt), 32'(g == 2));
        if (g != 0) begin
            we  = (g == 1) ? p_we : d_we;
            a   = (g == 1) ? p_addr : d_addr;
            wd  = (g == 1) ? p_wdata : d_wdata;
            hit = ((a >> DMEM_DEPTH) == 0);
            check("m_we", 32'(m_we), 32'(we && hit && !rst));
            check("m_addr", 32'(m_addr), 32'(a[DMEM_DEPTH-1:0]));
            check("m_wdata", 32'(m_wdata), 32'(wd));
            if (!we && !rst) begin
                if (g == 1) p_exp.push_back(hit ? ref_mem[a[DMEM_DEPTH-1:0]] : '0);
                else        d_exp.push_back(hit ? ref_mem[a[DMEM_DEPTH-1:0]] : '0);
            end
            if (we && hit && !rst) ref_mem[a[DMEM_DEPTH-1:0]] = wd;
            last_addr  = a[DMEM_DEPTH-1:0];
            last_wdata = wd;
            last_v     = 1'b1;
        end else begin
            check("m_we_idle", 32'(m_we), 32'd0);
            if (last_v) begin
                check("m_addr_hold", 32'(m_addr), 32'(last_addr));
                check("m_wdata_hold", 32'(m_wdata), 32'(last_wdata));
            end
        end
        hist.push_back(g);
        @(posedge clk);
        #1;
        if (rst || g == 0) begin
            own = 0;
            run = 0;
        end else if (g == own) begin
            run = (run < MAX_BURST) ? run + 1 : MAX_BURST;
        end else begin
            own = g;
            run = 1;
        end
        if (g == 1) p_req = 1'b0;
        if (g == 2) d_req = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int k;
        k = $urandom_range(9);
        if (k < 6)      return ADDR_W'($urandom_range(15));
        else if (k < 9) return ADDR_W'($urandom_range((1 << DMEM_DEPTH) - 1));
        else            return ADDR_W'($urandom) | ADDR_W'(1 << DMEM_DEPTH);
    endfunction

    task automatic gen_p(input int rate);
        if (!p_req && $urandom_range(99) < rate) begin
            p_req = 1'b1; p_we = 1'($urandom_range(1));
            p_addr = rand_addr(); p_wdata = DATA_W'($urandom);
        end
    endtask

    task automatic gen_d(input int rate);
        if (!d_req && $urandom_range(99) < rate) begin
            d_req = 1'b1; d_we = 1'($urandom_range(1));
            d_addr = rand_addr(); d_wdata = DATA_W'($urandom);
        end
    endtask

    task automatic put_p(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        p_req = 1'b1; p_we = we; p_addr = a; p_wdata = wd;
    endtask

    task automatic put_d(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    // monitor: every returned read is matched against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (p_rvalid) begin
                if (p_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL p_rvalid_unexpected actual=1 expected=0 at %0t", $time);
                end else check("p_rdata", 32'(p_rdata), 32'(p_exp.pop_front()));
            end else check("p_rdata_zero", 32'(p_rdata), 32'd0);
            if (d_rvalid) begin
                if (d_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_rvalid_unexpected actual=1 expected=0 at %0t", $time);
                end else check("d_rdata", 32'(d_rdata), 32'(d_exp.pop_front()));
            end else check("d_rdata_zero", 32'(d_rdata), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        int np;
        repeat (3) @(negedge clk);
        check("rst_p_gnt", 32'(p_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_p_rvalid", 32'(p_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_p_rdata", 32'(p_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(OWN_IDLE));
        mon_en = 1'b1;
        rst = 1'b0;
        step();

        // a read granted in the same cycle that reset is applied is dropped
        put_p(1'b0, 16'h0005, '0);
        rst = 1'b1;
        step();
        check("midrd_p_rvalid", 32'(p_rvalid), 32'd0);
        check("midrd_p_rdata", 32'(p_rdata), 32'd0);
        check("midrd_state", 32'(dut.state_q), 32'(OWN_IDLE));
        rst = 1'b0;

        // tie from idle, then 8/8 alternation with both always requesting
        h0 = hist.size();
        for (int i = 0; i < 32; i++) begin
            gen_p(100); gen_d(100);
            step();
        end
        for (int i = 0; i < 32; i++)
            check("alternate", 32'(hist[h0 + i]), (((i / 8) % 2) == 0) ? 32'd1 : 32'd2);
        p_req = 1'b0; d_req = 1'b0;
        step();

        // read latency: D writes, P reads back the next cycle
        put_d(1'b1, 16'h0010, 16'hBEEF);
        step();
        put_p(1'b0, 16'h0010, '0);
        step();
        check("lat_p_rvalid", 32'(p_rvalid), 32'd1);
        check("lat_p_rdata", 32'(p_rdata), 32'hBEEF);
        check("lat_d_rvalid", 32'(d_rvalid), 32'd0);

        // out-of-range accesses
        put_d(1'b1, 16'h0000, 16'h5A5A);
        step();
        put_p(1'b1, 16'hC000, 16'h1234);
        step();
        put_p(1'b0, 16'h0000, '0);
        step();
        check("oor_mem_kept", 32'(p_rdata), 32'h5A5A);
        put_p(1'b0, 16'hC001, '0);
        step();
        check("oor_rvalid", 32'(p_rvalid), 32'd1);
        check("oor_rdata", 32'(p_rdata), 32'd0);

        // parking: P alone, then D arrives after saturation, then both drop
        np = 0;
        for (int i = 0; i < 20; i++) begin
            gen_p(100);
            step();
            if (hist[hist.size() - 1] == 1) np++;
        end
        check("park_p_grants", 32'(np), 32'd20);
        gen_p(100);
        put_d(1'b0, 16'h0010, '0);
        step();
        check("park_d_gnt", 32'(hist[hist.size() - 1]), 32'd2);
        p_req = 1'b0; d_req = 1'b0;
        step();
        check("park_no_gnt", 32'(hist[hist.size() - 1]), 32'd0);
        check("park_state", 32'(dut.state_q), 32'(OWN_IDLE));

`ifdef DMEM_ARB_LOCK_EN
        // lock holds off the burst cap
        p_lock = 1'b1;
        h0 = hist.size();
        for (int i = 0; i < 12; i++) begin
            gen_p(100); gen_d(100);
            step();
        end
        for (int i = 0; i < 12; i++)
            check("lock_p_hold", 32'(hist[h0 + i]), 32'd1);
        p_lock = 1'b0;
        gen_p(100); gen_d(100);
        step();
        check("lock_release", 32'(hist[hist.size() - 1]), 32'd2);
`endif

        // randomized traffic with varying request rates
        for (int i = 0; i < 3000; i++) begin
            int rp, rd;
            rp = 20 + 20 * ((i / 200) % 5);
            rd = 100 - rp;
`ifdef DMEM_ARB_LOCK_EN
            p_lock = ($urandom_range(3) == 0);
            d_lock = ($urandom_range(3) == 0);
`endif
            gen_p(rp); gen_d(rd);
            step();
        end
        p_req = 1'b0; d_req = 1'b0;
        p_lock = 1'b0; d_lock = 1'b0;
        repeat (3) step();
        check("p_exp_drained", 32'(p_exp.size()), 32'd0);
        check("d_exp_drained", 32'(d_exp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
